// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control-bundle bit indices and types for the MIPS pipeline
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    localparam int REG_WRITE_BIT = 0;
    localparam int ALU_SRC_BIT   = 1;
    localparam int MEM_WRITE_BIT = 2;
    localparam int MEM_READ_BIT  = 3;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    function automatic logic is_load(input ctrl_t c);
        return c[MEM_READ_BIT];
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/writeback/EX-side signal bundle of the ID/EX pipeline register
interface id_ex_stage_if
    import mips_pkg::*;
    ();

    logic     id_valid;
    reg_idx_t id_rs;
    reg_idx_t id_rt;
    reg_idx_t id_rd;
    word_t    rd1;
    word_t    rd2;
    word_t    id_imm;
    ctrl_t    id_ctrl;
    logic     wb_we;
    reg_idx_t wb_addr;
    word_t    wb_data;
    logic     ex_stall;
    logic     ex_flush;

    logic     ex_valid;
    word_t    ex_rs_val;
    word_t    ex_rt_val;
    word_t    ex_imm;
    ctrl_t    ex_ctrl;
    reg_idx_t ex_rs;
    reg_idx_t ex_rt;
    reg_idx_t ex_rd;
    logic     hazard_stall;
    logic [31:0] bubble_cnt;
    logic [31:0] hold_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, rd1, rd2, id_imm, id_ctrl,
        output wb_we, wb_addr, wb_data, ex_stall, ex_flush,
        input  ex_valid, ex_rs_val, ex_rt_val, ex_imm, ex_ctrl,
        input  ex_rs, ex_rt, ex_rd, hazard_stall, bubble_cnt, hold_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, rd1, rd2, id_imm, id_ctrl,
        input  wb_we, wb_addr, wb_data, ex_stall, ex_flush,
        output ex_valid, ex_rs_val, ex_rt_val, ex_imm, ex_ctrl,
        output ex_rs, ex_rt, ex_rd, hazard_stall, bubble_cnt, hold_cnt
    );

endinterface

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - per-operand select: r0 -> 0, same-cycle writeback, else register file
module operand_bypass
    import mips_pkg::*;
(
    input  reg_idx_t i_idx,
    input  logic     i_wb_we,
    input  reg_idx_t i_wb_addr,
    input  word_t    i_wb_data,
    input  word_t    i_rf_data,
    output word_t    o_val
);

    logic w_wb_hit;

    assign w_wb_hit = i_wb_we && (i_wb_addr != REG_ZERO) && (i_wb_addr == i_idx);

    always_comb begin
        o_val = i_rf_data;
        if (i_idx == REG_ZERO) begin
            o_val = '0;
        end else if (w_wb_hit) begin
            o_val = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with writeback bypass/snoop and load-use bubble
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    word_t    w_rs_sel;
    word_t    w_rt_sel;
    logic     w_hazard;
    logic     w_snoop_rs;
    logic     w_snoop_rt;

    logic     r_ex_valid;
    word_t    r_ex_rs_val;
    word_t    r_ex_rt_val;
    word_t    r_ex_imm;
    ctrl_t    r_ex_ctrl;
    reg_idx_t r_ex_rs;
    reg_idx_t r_ex_rt;
    reg_idx_t r_ex_rd;

    operand_bypass u_bypass_rs (
        .i_idx     (bus.id_rs),
        .i_wb_we   (bus.wb_we),
        .i_wb_addr (bus.wb_addr),
        .i_wb_data (bus.wb_data),
        .i_rf_data (bus.rd1),
        .o_val     (w_rs_sel)
    );

    operand_bypass u_bypass_rt (
        .i_idx     (bus.id_rt),
        .i_wb_we   (bus.wb_we),
        .i_wb_addr (bus.wb_addr),
        .i_wb_data (bus.wb_data),
        .i_rf_data (bus.rd2),
        .o_val     (w_rt_sel)
    );

    // A load sitting here whose destination feeds the next instruction forces one bubble.
    assign w_hazard = bus.id_valid && r_ex_valid && is_load(r_ex_ctrl)
                   && (r_ex_rd != REG_ZERO)
                   && ((r_ex_rd == bus.id_rs) || (r_ex_rd == bus.id_rt))
                   && !bus.ex_flush;

    assign w_snoop_rs = bus.wb_we && (bus.wb_addr != REG_ZERO) && (bus.wb_addr == r_ex_rs);
    assign w_snoop_rt = bus.wb_we && (bus.wb_addr != REG_ZERO) && (bus.wb_addr == r_ex_rt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_rs_val <= '0;
            r_ex_rt_val <= '0;
            r_ex_imm    <= '0;
            r_ex_ctrl   <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_rd     <= '0;
        end else if (bus.ex_flush) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (bus.ex_stall) begin
            // Held operands would go stale if the register file is written underneath them.
            if (w_snoop_rs) r_ex_rs_val <= bus.wb_data;
            if (w_snoop_rt) r_ex_rt_val <= bus.wb_data;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else begin
            r_ex_valid  <= bus.id_valid;
            r_ex_rs_val <= w_rs_sel;
            r_ex_rt_val <= w_rt_sel;
            r_ex_imm    <= bus.id_imm;
            r_ex_ctrl   <= bus.id_valid ? bus.id_ctrl : '0;
            r_ex_rs     <= bus.id_rs;
            r_ex_rt     <= bus.id_rt;
            r_ex_rd     <= bus.id_rd;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_hold_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else if (!bus.ex_flush) begin
            if (bus.ex_stall) begin
                if (r_hold_cnt != 32'hFFFF_FFFF) r_hold_cnt <= r_hold_cnt + 32'd1;
            end else if (w_hazard) begin
                if (r_bubble_cnt != 32'hFFFF_FFFF) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign bus.bubble_cnt = r_bubble_cnt;
    assign bus.hold_cnt   = r_hold_cnt;
`else
    assign bus.bubble_cnt = '0;
    assign bus.hold_cnt   = '0;
`endif

    assign bus.hazard_stall = w_hazard;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_rs_val    = r_ex_rs_val;
    assign bus.ex_rt_val    = r_ex_rt_val;
    assign bus.ex_imm       = r_ex_imm;
    assign bus.ex_ctrl      = r_ex_ctrl;
    assign bus.ex_rs        = r_ex_rs;
    assign bus.ex_rt        = r_ex_rt;
    assign bus.ex_rd        = r_ex_rd;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file.
- Captures the two read operands, immediate, control bundle and register indices each cycle, and presents them to the execute stage.
- Bypasses same-cycle writeback data around the register file and snoops writebacks while held.
- Detects load-use hazards and inserts a bubble on its own output; upstream holds ID on hazard_stall.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register index width
CTRL_W, 8, control bundle width
MEM_READ_BIT, 3, index of the load flag inside the control bundle

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction this cycle
id_rs  in  REG_AW  source index 1
id_rt  in  REG_AW  source index 2
id_rd  in  REG_AW  destination index
rd1  in  DATA_W  register-file data for id_rs
rd2  in  DATA_W  register-file data for id_rt
id_imm  in  DATA_W  sign-extended immediate
id_ctrl  in  CTRL_W  decoded control bundle
wb_we  in  1  writeback enable (same signal driving the register-file write port)
wb_addr  in  REG_AW  writeback index
wb_data  in  DATA_W  writeback data
ex_stall  in  1  execute cannot accept; hold contents
ex_flush  in  1  kill the instruction held in this stage
ex_valid  out  1  output holds a real instruction
ex_rs_val  out  DATA_W  operand 1
ex_rt_val  out  DATA_W  operand 2
ex_imm  out  DATA_W  immediate
ex_ctrl  out  CTRL_W  control bundle
ex_rs, ex_rt, ex_rd  out  REG_AW each  indices, used by forwarding logic
hazard_stall  out  1  combinational; upstream must hold PC and IF/ID
bubble_cnt  out  32  bubbles inserted (see Optional Feature)
hold_cnt  out  32  cycles held by ex_stall (see Optional Feature)

Behaviour:
- Reset: all outputs registered to 0 on the rising clk edge while reset=1, including ex_valid and both counters. Reset overrides every other input.
- Operand select, applied per operand:
  - Source index 0 yields 0.
  - Otherwise, if wb_we=1, wb_addr≠0 and wb_addr equals the index, the operand is wb_data.
  - Otherwise the operand is rd1 or rd2.
- hazard_stall = id_valid & ex_valid & ex_ctrl[MEM_READ_BIT] & (ex_rd≠0) & (ex_rd==id_rs | ex_rd==id_rt) & ~ex_flush.
- Per-edge priority (highest first):
  - reset
  - ex_flush: ex_valid←0, ex_ctrl←0; other fields don't-care.
  - ex_stall: hold all fields. If wb_we=1 and wb_addr≠0 matches the held ex_rs (or ex_rt), replace ex_rs_val (or ex_rt_val) with wb_data.
  - hazard_stall: bubble. ex_valid←0, ex_ctrl←0. The load stays ahead; ID is re-presented next cycle.
  - Normal: load all fields from ID. ex_valid←id_valid. ex_ctrl←id_ctrl when id_valid=1, else 0.
- Latency: one cycle from ID inputs to ex_* outputs. No combinational path from rd1, rd2 or wb_* to outputs other than hazard_stall.
- ex_stall together with hazard_stall: hold wins, and hazard_stall stays asserted, so ID remains held.
- Reset mid-stall clears everything. hazard_stall is 0 after reset because ex_valid=0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - bubble_cnt increments on each edge that inserts a hazard bubble.
  - hold_cnt increments on each edge with ex_stall=1 and no reset or flush.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package mips_pkg:
  - DATA_W, REG_AW, CTRL_W
  - control bit indices (MEM_READ_BIT, REG_WRITE_BIT, …)
  - REG_ZERO constant
  - control-bundle typedef
- Sub-module: operand_bypass, a combinational zero/writeback/regfile select, instantiated twice (rs, rt).
- Held-operand snoop logic stays in the top module.

Test Plan:
- Basic capture: id_valid=1, rs=3, rt=4, rd1=0x11, rd2=0x22, imm=0xFFFFFFF0. Next cycle: ex_valid=1, ex_rs_val=0x11, ex_rt_val=0x22, ex_imm=0xFFFFFFF0.
- Same-cycle bypass: id_rs=5, rd1=0xAAAA, wb_we=1, wb_addr=5, wb_data=0x1234. Then ex_rs_val=0x1234. Repeating with wb_addr=0 or id_rs=0 gives 0xAAAA and 0 respectively.
- Load-use: held load with ex_ctrl[3]=1, ex_rd=8; ID has rs=8. hazard_stall=1 the same cycle, ex_valid=0 next cycle, bubble_cnt=1 (macro on). The re-presented instruction is captured the following cycle.
- Hold with snoop: ex_stall=1 for 3 cycles, held ex_rt=9; wb writes 0xBEEF to r9 in cycle 2. Outputs stay constant except ex_rt_val=0xBEEF from cycle 3; hold_cnt=3.
- Flush priority: ex_flush=1 with ex_stall=1 and id_valid=1. Next cycle: ex_valid=0, ex_ctrl=0.
- Reset mid-operation: reset=1 while ex_valid=1 and ex_stall=1. Next cycle: all outputs 0, hazard_stall=0, counters 0.
